// File: rtl/conc_stim_sequencer_if.sv
// Program-load bus for the stimulus sequencer: host writes opcodes into
// the sequencer RAM with a valid/ready handshake.
interface conc_stim_sequencer_if #(
  parameter int ADDR_W = 7,
  parameter int X_W    = 6
);
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_addr;
  logic [X_W+1:0]    ld_data;

  modport master (output ld_valid, output ld_addr, output ld_data, input  ld_ready);
  modport slave  (input  ld_valid, input  ld_addr, input  ld_data, output ld_ready);
endinterface

// File: rtl/conc_stim_sequencer.sv
// Opcode-stream player: replays a window of program RAM onto the b11
// datapath inputs, with loop count, hold, abort and a per-opcode trace.
module conc_stim_sequencer #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 101,
  parameter int X_W    = 6,
  parameter int LOOP_W = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  conc_stim_sequencer_if.slave  ld_if,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic [LOOP_W-1:0]     loops,
  input  logic                  hold,
  input  logic                  abort,
  output logic [X_W-1:0]        x_in,
  output logic                  stbi,
  output logic                  obs,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  trace_valid,
  output logic [ADDR_W-1:0]     trace_pc
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);

  state_t             r_state;
  state_t             w_next;
  logic [X_W+1:0]     r_mem [DEPTH];
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_first;
  logic [ADDR_W-1:0]  r_last;
  logic [LOOP_W-1:0]  r_loop_cnt;
  logic [X_W+1:0]     r_op;
  logic [ADDR_W-1:0]  r_trace_pc;
  logic               r_trace_valid;
  logic               r_err;

  logic w_idle_like;
  logic w_wr_acc;
  logic w_wr_inrange;
  logic w_start_req;
  logic w_win_ok;
  logic w_start_ok;
  logic w_start_bad;
  logic w_at_last;
  logic w_emit;
  logic w_clear;

  assign w_idle_like    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign ld_if.ld_ready = w_idle_like;
  assign w_wr_acc       = ld_if.ld_valid && w_idle_like;
  assign w_wr_inrange   = {1'b0, ld_if.ld_addr} < LP_DEPTH;
  // A write in the same cycle always wins over start.
  assign w_start_req    = start && w_idle_like && !ld_if.ld_valid;
  assign w_win_ok       = (first_addr <= last_addr) && ({1'b0, last_addr} < LP_DEPTH);
  assign w_start_ok     = w_start_req && w_win_ok;
  assign w_start_bad    = w_start_req && !w_win_ok;
  assign w_at_last      = (r_pc == r_last);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_emit  = 1'b0;
    w_clear = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) w_next = S_RUN;
      end
      S_DONE: begin
        if (w_wr_acc)        w_next = S_IDLE;
        else if (w_start_ok) w_next = S_RUN;
      end
      S_RUN: begin
        if (abort) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (hold) begin
          w_next = S_PAUSE;
        end else begin
          w_emit = 1'b1;
          if (w_at_last && (r_loop_cnt == '0)) w_next = S_DONE;
        end
      end
      S_PAUSE: begin
        // Resuming costs one cycle; emission restarts from the frozen pc.
        if (abort) begin
          w_next  = S_IDLE;
          w_clear = 1'b1;
        end else if (!hold) begin
          w_next = S_RUN;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_wr_acc && w_wr_inrange) r_mem[ld_if.ld_addr] <= ld_if.ld_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc          <= '0;
      r_first       <= '0;
      r_last        <= '0;
      r_loop_cnt    <= '0;
      r_op          <= '0;
      r_trace_pc    <= '0;
      r_trace_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_trace_valid <= w_emit;
      r_err         <= (w_wr_acc && !w_wr_inrange) || w_start_bad;
      if (w_start_ok) begin
        r_pc       <= first_addr;
        r_first    <= first_addr;
        r_last     <= last_addr;
        r_loop_cnt <= loops;
      end
      if (w_emit) begin
        r_op       <= r_mem[r_pc];
        r_trace_pc <= r_pc;
        if (!w_at_last) begin
          r_pc <= r_pc + 1'b1;
        end else if (r_loop_cnt != '0) begin
          r_loop_cnt <= r_loop_cnt - 1'b1;
          r_pc       <= r_first;
        end
      end
      if (w_clear) r_op <= '0;
    end
  end

  assign {obs, stbi, x_in} = r_op;
  assign busy        = (r_state == S_RUN) || (r_state == S_PAUSE);
  assign done        = (r_state == S_DONE);
  assign err         = r_err;
  assign trace_valid = r_trace_valid;
  assign trace_pc    = r_trace_pc;

endmodule
